// File: rtl/tt_serial_adder_pkg.sv
// Shared types and pin maps for the bit-serial adder/subtractor.
package tt_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // uio_in control bits
  localparam int unsigned CTL_LOAD_A = 0;
  localparam int unsigned CTL_LOAD_B = 1;
  localparam int unsigned CTL_START  = 2;
  localparam int unsigned CTL_MODE   = 3;

  // uio_out status bits
  localparam int unsigned STS_CARRY = 4;
  localparam int unsigned STS_BUSY  = 5;
  localparam int unsigned STS_DONE  = 6;
  localparam int unsigned STS_OVF   = 7;

  localparam logic [7:0] UIO_OE = 8'hF0;

endpackage

// File: rtl/serial_full_adder_bit.sv
// One-bit full adder built from two half adders; carry storage lives in the caller.
module serial_full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_c_o,
  output logic cout_c_o
);

  logic ha0_sum, ha0_carry, ha1_carry;

  assign ha0_sum   = a_i ^ b_i;
  assign ha0_carry = a_i & b_i;
  assign sum_c_o   = ha0_sum ^ cin_i;
  assign ha1_carry = ha0_sum & cin_i;
  assign cout_c_o  = ha0_carry | ha1_carry;

endmodule

// File: rtl/tt_um_akaur014_serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per enabled clock.
module tt_um_akaur014_serial_adder
  import tt_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] shift_q, shift_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_ff_q, carry_ff_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, mode_q, mode_d;

  logic             ld_a, ld_b, start, mode;
  logic [WIDTH-1:0] bit_sel, b_eff;
  logic             a_bit, b_bit, sum_bit, cout_bit;
  logic             unused_c;

  assign ld_a  = uio_in[CTL_LOAD_A];
  assign ld_b  = uio_in[CTL_LOAD_B];
  assign start = uio_in[CTL_START];
  assign mode  = uio_in[CTL_MODE];

  assign unused_c = ^{uio_in[7:4], ui_in};

  // Current bit of each operand; subtract uses the inverted B with carry-in 1
  assign bit_sel = WIDTH'(1) << cnt_q;
  assign b_eff   = mode_q ? ~b_q : b_q;
  assign a_bit   = |(a_q & bit_sel);
  assign b_bit   = |(b_eff & bit_sel);

  serial_full_adder_bit u_fa (
    .a_i      (a_bit),
    .b_i      (b_bit),
    .cin_i    (carry_ff_q),
    .sum_c_o  (sum_bit),
    .cout_c_o (cout_bit)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    shift_d    = shift_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    carry_ff_d = carry_ff_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    mode_d     = mode_q;
    case (state_q)
      IDLE, DONE: begin
        if (ld_a) a_d = ui_in[WIDTH-1:0];
        if (ld_b) b_d = ui_in[WIDTH-1:0];
        if (start) begin
          state_d    = RUN;
          mode_d     = mode;
          carry_ff_d = mode;
          cnt_d      = '0;
        end else if (ld_a || ld_b) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        shift_d    = (shift_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
        carry_ff_d = cout_bit;
        cnt_d      = cnt_q + CNT_W'(1);
        // Last bit: carry_ff_q is the carry into the MSB
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = shift_d;
          carry_d  = cout_bit;
          ovf_d    = carry_ff_q ^ cout_bit;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      shift_q    <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_ff_q <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      mode_q     <= 1'b0;
    end else if (ena) begin
      a_q        <= a_d;
      b_q        <= b_d;
      shift_q    <= shift_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      carry_ff_q <= carry_ff_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      mode_q     <= mode_d;
    end
  end

  assign uo_out = 8'(result_q);
  assign uio_oe = UIO_OE;

  always_comb begin
    uio_out            = '0;
    uio_out[STS_CARRY] = carry_q;
    uio_out[STS_BUSY]  = (state_q == RUN);
    uio_out[STS_DONE]  = (state_q == DONE);
    uio_out[STS_OVF]   = ovf_q;
  end

endmodule

// File: tb/tb_tt_um_akaur014_serial_adder.sv
// Scoreboard bench: driver queues expected results, monitors pop them on each done rise.
module tb_tt_um_akaur014_serial_adder;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
    int         lat;
    int         start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena8, ena4;
  logic [7:0] ui8, uio8, ui4, uio4;
  logic [7:0] uo8, uio_out8, oe8, uo4, uio_out4, oe4;

  exp_t q8[$];
  exp_t q4[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  tt_um_akaur014_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .ui_in(ui8), .uio_in(uio8),
    .uo_out(uo8), .uio_out(uio_out8), .uio_oe(oe8)
  );

  tt_um_akaur014_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .ui_in(ui4), .uio_in(uio4),
    .uo_out(uo4), .uio_out(uio_out4), .uio_oe(oe4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit w4, input logic [7:0] ui, input logic [7:0] uio);
    if (w4) begin ui4 = ui; uio4 = uio; end
    else    begin ui8 = ui; uio8 = uio; end
  endtask

  task automatic drive(input bit w4, input logic [7:0] ui, input logic [7:0] uio);
    set_in(w4, ui, uio);
    tick();
    set_in(w4, 8'h00, 8'h00);
  endtask

  task automatic load(input bit w4, input logic [7:0] a, input logic [7:0] b);
    drive(w4, a, 8'h01);
    drive(w4, b, 8'h02);
  endtask

  task automatic start_op(input bit w4, input logic [7:0] ui, input logic [7:0] extra,
                          input bit sub, input logic [7:0] res, input bit c, input bit v,
                          input int lat);
    exp_t e;
    set_in(w4, ui, extra | 8'h04 | (sub ? 8'h08 : 8'h00));
    tick();
    e.res = res; e.c = c; e.v = v; e.lat = lat; e.start_cyc = cyc;
    if (w4) q4.push_back(e); else q8.push_back(e);
    set_in(w4, 8'h00, 8'h00);
  endtask

  task automatic wait_done(input bit w4);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if ((w4 ? q4.size() : q8.size()) == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_w%0d: got no done required done", w4 ? 4 : 8);
      if (w4) q4.delete(); else q8.delete();
    end
  endtask

  // Monitor for the 8-bit instance
  int         busy8 = 0;
  logic       pdone8 = 1'b0;
  logic [9:0] hold8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy8 = 0; pdone8 = 1'b0; hold8 = '0;
    end else begin
      chk("oe8", oe8, 8'hF0);
      chk("sts8_lo", uio_out8[3:0], 4'h0);
      if (uio_out8[5]) begin
        busy8++;
        chk("hold8", {uio_out8[4], uio_out8[7], uo8}, hold8);
      end
      if (uio_out8[6] && !pdone8) begin
        if (q8.size() == 0) begin
          chk("spurious_done8", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("res8", uo8, e.res);
          chk("carry8", uio_out8[4], e.c);
          chk("ovf8", uio_out8[7], e.v);
          chk("lat8", cyc - e.start_cyc, e.lat);
          chk("busy_cycles8", busy8, e.lat);
          hold8 = {e.c, e.v, e.res};
        end
        busy8 = 0;
      end
      pdone8 = uio_out8[6];
    end
  end

  // Monitor for the 4-bit instance
  int         busy4 = 0;
  logic       pdone4 = 1'b0;
  logic [9:0] hold4 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy4 = 0; pdone4 = 1'b0; hold4 = '0;
    end else begin
      chk("oe4", oe4, 8'hF0);
      chk("uo4_hi", uo4[7:4], 4'h0);
      if (uio_out4[5]) begin
        busy4++;
        chk("hold4", {uio_out4[4], uio_out4[7], uo4}, hold4);
      end
      if (uio_out4[6] && !pdone4) begin
        if (q4.size() == 0) begin
          chk("spurious_done4", 1, 0);
        end else begin
          e = q4.pop_front();
          chk("res4", uo4, e.res);
          chk("carry4", uio_out4[4], e.c);
          chk("ovf4", uio_out4[7], e.v);
          chk("lat4", cyc - e.start_cyc, e.lat);
          chk("busy_cycles4", busy4, e.lat);
          hold4 = {e.c, e.v, e.res};
        end
        busy4 = 0;
      end
      pdone4 = uio_out4[6];
    end
  end

  initial begin
    rst_n = 1'b0; ena8 = 1'b1; ena4 = 1'b1;
    ui8 = '0; uio8 = '0; ui4 = '0; uio4 = '0;
    repeat (2) tick();
    chk("rst_uo8", uo8, 8'h00);
    chk("rst_sts8", uio_out8, 8'h00);
    chk("rst_oe8", oe8, 8'hF0);
    rst_n = 1'b1;
    tick();

    // 0x35+0x4A, with start and load_a=0xAA attempted mid-run
    load(0, 8'h35, 8'h4A);
    start_op(0, 8'h00, 8'h00, 0, 8'h7F, 0, 0, 8);
    tick();
    drive(0, 8'hAA, 8'h05);
    wait_done(0);
    // Back-to-back restart from DONE proves a_reg kept 0x35
    start_op(0, 8'h00, 8'h00, 0, 8'h7F, 0, 0, 8);
    wait_done(0);

    // Unsigned wrap, then load_a+start in DONE reusing b=0x01
    load(0, 8'hFF, 8'h01);
    start_op(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8);
    wait_done(0);
    start_op(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 8);
    wait_done(0);

    // Subtraction: borrow, then signed overflow
    load(0, 8'h10, 8'h20);
    start_op(0, 8'h00, 8'h00, 1, 8'hF0, 0, 0, 8);
    wait_done(0);
    load(0, 8'h80, 8'h01);
    start_op(0, 8'h00, 8'h00, 1, 8'h7F, 1, 1, 8);
    wait_done(0);

    // Three-cycle ena pause mid-run stretches latency to 11
    load(0, 8'h35, 8'h4A);
    start_op(0, 8'h00, 8'h00, 0, 8'h7F, 0, 0, 11);
    tick(); tick();
    ena8 = 1'b0;
    repeat (3) tick();
    ena8 = 1'b1;
    wait_done(0);

    // Reset during RUN aborts at once and clears operands
    start_op(0, 8'h00, 8'h00, 0, 8'h7F, 0, 0, 8);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_uo8", uo8, 8'h00);
    chk("abort_sts8", uio_out8, 8'h00);
    q8.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_op(0, 8'h00, 8'h00, 1, 8'h00, 1, 0, 8);
    wait_done(0);

    // WIDTH=4: upper operand bits ignored, 9+8 wraps with overflow
    load(1, 8'hF9, 8'hF8);
    start_op(1, 8'h00, 8'h00, 0, 8'h01, 1, 1, 4);
    wait_done(1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
